sma_win_ctrl: RTL and testbench

SMA_WIN_CTRL -- requirements
Module: sma_win_ctrl

---
 rtl/sma_win_ctrl.sv | 120 ++++++++++++
 tb/tb_sma_win_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sma_win_ctrl.sv
// Window controller for a power-of-two moving-average delay line: sweeps the line
// to zero on every window change, then tracks fill level and write index per sample.
module sma_win_ctrl #(
  parameter int MAX_SEL = 15,
  parameter int ADDR_W  = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_update_strobe,
  input  logic [31:0]       i_window_sel,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_we,
  output logic              o_wzero,
  output logic              o_sum_clr,
  output logic [3:0]        o_shift,
  output logic              o_valid,
  output logic              o_busy,
  output logic [15:0]       o_drop_cnt
);

  typedef enum logic [1:0] {ST_CLEAR, ST_FILL, ST_RUN} state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_sel_req, w_sel_clamp;
  logic [3:0]        r_shift, w_shift_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt, w_mask, w_addr_inc;
  logic [15:0]       r_fill_cnt, w_fill_nxt;
  logic [15:0]       r_drop_cnt, w_drop_nxt;
  logic              r_first, w_first_nxt;
  logic              r_valid, w_valid_nxt;
  logic              w_change, w_accept, w_drop;

  // w_mask doubles as N-1 and as the modulo-N wrap mask for the index
  assign w_sel_clamp = (i_window_sel > 32'(MAX_SEL)) ? 4'(MAX_SEL) : i_window_sel[3:0];
  assign w_mask      = ~({ADDR_W{1'b1}} << r_shift);
  assign w_addr_inc  = (r_addr + ADDR_W'(1)) & w_mask;

  assign w_change = (r_sel_req != r_shift);
  assign w_accept = i_update_strobe && !w_change && (r_state != ST_CLEAR);
  assign w_drop   = i_update_strobe && !w_accept;

  assign o_we       = (r_state == ST_CLEAR) || w_accept;
  assign o_wzero    = (r_state == ST_CLEAR);
  assign o_busy     = (r_state == ST_CLEAR);
  assign o_sum_clr  = (r_state == ST_CLEAR) && r_first;
  assign o_addr     = r_addr;
  assign o_shift    = r_shift;
  assign o_valid    = r_valid;
  assign o_drop_cnt = r_drop_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_addr_nxt  = r_addr;
    w_fill_nxt  = r_fill_cnt;
    w_first_nxt = r_first;
    if (w_change) begin
      w_shift_nxt = r_sel_req;
      w_state_nxt = ST_CLEAR;
      w_addr_nxt  = '0;
      w_fill_nxt  = '0;
      w_first_nxt = 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          w_first_nxt = 1'b0;
          if (r_addr == w_mask) begin
            w_state_nxt = ST_FILL;
            w_addr_nxt  = '0;
            w_fill_nxt  = '0;
          end else begin
            w_addr_nxt = w_addr_inc;
          end
        end
        ST_FILL: begin
          if (w_accept) begin
            w_addr_nxt = w_addr_inc;
            w_fill_nxt = r_fill_cnt + 16'd1;
            // this strobe delivers the Nth sample
            if (r_fill_cnt == 16'(w_mask)) w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_accept) w_addr_nxt = w_addr_inc;
        end
        default: begin
          w_state_nxt = ST_CLEAR;
          w_addr_nxt  = '0;
          w_fill_nxt  = '0;
          w_first_nxt = 1'b1;
        end
      endcase
    end
    w_drop_nxt  = (w_drop && (r_drop_cnt != 16'hFFFF)) ? r_drop_cnt + 16'd1 : r_drop_cnt;
    w_valid_nxt = (w_state_nxt == ST_RUN);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_CLEAR;
      r_sel_req  <= '0;
      r_shift    <= '0;
      r_addr     <= '0;
      r_fill_cnt <= '0;
      r_drop_cnt <= '0;
      r_first    <= 1'b1;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel_req  <= w_sel_clamp;
      r_shift    <= w_shift_nxt;
      r_addr     <= w_addr_nxt;
      r_fill_cnt <= w_fill_nxt;
      r_drop_cnt <= w_drop_nxt;
      r_first    <= w_first_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

endmodule

// File: tb/tb_sma_win_ctrl.sv
// Self-checking bench for sma_win_ctrl: directed scenarios plus random traffic,
// each cycle compared against a behavioural window model.
module tb_sma_win_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic [31:0] sel = 32'd0;
  logic [14:0] o_addr;
  logic        o_we, o_wzero, o_sum_clr, o_valid, o_busy;
  logic [3:0]  o_shift;
  logic [15:0] o_drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sma_win_ctrl #(.MAX_SEL(15), .ADDR_W(15)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_update_strobe(stb), .i_window_sel(sel),
    .o_addr(o_addr), .o_we(o_we), .o_wzero(o_wzero), .o_sum_clr(o_sum_clr),
    .o_shift(o_shift), .o_valid(o_valid), .o_busy(o_busy), .o_drop_cnt(o_drop_cnt)
  );

  wire [39:0] dut_vec = {o_addr, o_we, o_wzero, o_sum_clr, o_shift, o_valid, o_busy, o_drop_cnt};

  // Behavioural model: mode 0 = zeroing sweep, 1 = filling, 2 = running
  localparam int MCLR = 0, MFILL = 1, MRUN = 2;
  int m_req, m_shift, m_mode, m_idx, m_first, m_pos, m_count, m_valid, m_drop;
  int m_n;
  bit m_chg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req = 0; m_shift = 0; m_mode = MCLR; m_idx = 0; m_first = 1;
      m_pos = 0; m_count = 0; m_valid = 0; m_drop = 0;
    end else begin
      m_n   = 1 << m_shift;
      m_chg = (m_req != m_shift);
      if (stb && (m_mode == MCLR || m_chg) && m_drop < 65535) m_drop = m_drop + 1;
      if (m_chg) begin
        m_shift = m_req; m_mode = MCLR; m_idx = 0; m_first = 1; m_pos = 0; m_count = 0;
      end else if (m_mode == MCLR) begin
        m_first = 0;
        if (m_idx == m_n - 1) begin
          m_mode = MFILL; m_pos = 0; m_count = 0;
        end else m_idx = m_idx + 1;
      end else if (stb) begin
        m_pos = (m_pos + 1) % m_n;
        if (m_mode == MFILL) begin
          m_count = m_count + 1;
          if (m_count == m_n) m_mode = MRUN;
        end
      end
      m_req   = (sel > 32'd15) ? 15 : int'(sel);
      m_valid = (m_mode == MRUN) ? 1 : 0;
    end
  end

  function automatic logic [39:0] exp_vec();
    logic [14:0] a;
    logic        we;
    bit          clr;
    clr = (m_mode == MCLR);
    a   = clr ? m_idx[14:0] : m_pos[14:0];
    we  = clr || (stb && (m_req == m_shift));
    return {a, we, clr, clr && (m_first != 0), m_shift[3:0], m_valid != 0, clr, m_drop[15:0]};
  endfunction

  task automatic drive(input bit s, input int unsigned w);
    @(posedge clk); #1;
    stb = s;
    sel = w;
  endtask

  task automatic test_reset();
    stb = 1'b0; sel = 32'd3; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_model: dut=%h model=%h", dut_vec, exp_vec());
    end
    checks++;
    if ({o_addr, o_valid, o_drop_cnt, o_shift, o_busy, o_sum_clr} !== {15'd0, 1'b0, 16'd0, 4'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL reset_values: addr=%0d valid=%b drop=%0d shift=%0d busy=%b clr=%b",
                         o_addr, o_valid, o_drop_cnt, o_shift, o_busy, o_sum_clr);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_clear_sweep();
    int len = 0, pulses = 0;
    @(negedge clk);
    checks++;
    if ({o_busy, o_sum_clr, o_shift, o_addr} !== {1'b1, 1'b1, 4'd0, 15'd0}) begin
      errors++; $display("FAIL first_clear: busy=%b clr=%b shift=%0d addr=%0d want 1 1 0 0",
                         o_busy, o_sum_clr, o_shift, o_addr);
    end
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 3);
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL sweep_model: cyc=%0d dut=%h model=%h", c, dut_vec, exp_vec());
      end
      if (o_busy && o_shift == 4'd3) begin
        checks++;
        if ({o_addr, o_we, o_wzero} !== {15'(len), 1'b1, 1'b1}) begin
          errors++; $display("FAIL sweep_addr: addr=%0d we=%b wz=%b want %0d 1 1", o_addr, o_we, o_wzero, len);
        end
        if (o_sum_clr) pulses++;
        len++;
      end
    end
    checks++;
    if (len != 8 || pulses != 1) begin
      errors++; $display("FAIL sweep_len: len=%0d pulses=%0d want 8 1", len, pulses);
    end
    checks++;
    if ({o_busy, o_addr, o_valid} !== {1'b0, 15'd0, 1'b0}) begin
      errors++; $display("FAIL sweep_to_fill: busy=%b addr=%0d valid=%b", o_busy, o_addr, o_valid);
    end
  endtask

  task automatic test_fill();
    int waited = 0;
    do begin
      drive(1'b0, 2);
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL fill_wait_model: dut=%h model=%h", dut_vec, exp_vec());
      end
      waited++;
    end while ((o_busy || o_shift != 4'd2) && waited < 50);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2);
      @(negedge clk);
      checks++;
      if ({o_we, o_wzero, o_valid} !== 3'b100) begin
        errors++; $display("FAIL fill_strobe%0d: we=%b wz=%b valid=%b want 1 0 0", i, o_we, o_wzero, o_valid);
      end
      for (int k = 0; k < 2; k++) begin
        drive(1'b0, 2);
        @(negedge clk);
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++; $display("FAIL fill_model: dut=%h model=%h", dut_vec, exp_vec());
        end
      end
      checks++;
      if (o_addr !== 15'((i + 1) % 4)) begin
        errors++; $display("FAIL fill_addr%0d: addr=%0d want %0d", i, o_addr, (i + 1) % 4);
      end
    end
    checks++;
    if (o_valid !== 1'b1) begin
      errors++; $display("FAIL fill_valid: valid=%b want 1", o_valid);
    end
  endtask

  task automatic test_change_run();
    int waited = 0, len = 0;
    logic [15:0] d0;
    do begin
      drive(1'b0, 4);
      @(negedge clk);
      waited++;
    end while ((o_busy || o_shift != 4'd4) && waited < 50);
    for (int i = 0; i < 17; i++) begin
      drive(i < 16, 4);
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL run_fill_model: i=%0d dut=%h model=%h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (o_valid !== 1'b1) begin
      errors++; $display("FAIL run_valid: valid=%b want 1", o_valid);
    end
    d0 = o_drop_cnt;
    drive(1'b0, 1);
    drive(1'b1, 1);
    @(negedge clk);
    checks++;
    if (o_we !== 1'b0) begin
      errors++; $display("FAIL change_drop_we: we=%b want 0", o_we);
    end
    drive(1'b0, 1);
    @(negedge clk);
    checks++;
    if ({o_drop_cnt, o_valid, o_busy, o_shift, o_sum_clr} !== {d0 + 16'd1, 1'b0, 1'b1, 4'd1, 1'b1}) begin
      errors++; $display("FAIL change_effect: drop=%0d valid=%b busy=%b shift=%0d clr=%b want %0d 0 1 1 1",
                         o_drop_cnt, o_valid, o_busy, o_shift, o_sum_clr, d0 + 16'd1);
    end
    while (o_busy && len < 20) begin
      len++;
      drive(1'b0, 1);
      @(negedge clk);
    end
    checks++;
    if (len != 2 || o_addr !== 15'd0) begin
      errors++; $display("FAIL change_clear_len: len=%0d addr=%0d want 2 0", len, o_addr);
    end
  endtask

  task automatic test_restart();
    int waited = 0, len = 0;
    do begin
      drive(1'b0, 15);
      @(negedge clk);
      waited++;
    end while (!(o_busy && o_shift == 4'd15 && o_addr == 15'd100) && waited < 300);
    checks++;
    if (o_addr !== 15'd100) begin
      errors++; $display("FAIL restart_reach: addr=%0d want 100", o_addr);
    end
    waited = 0;
    do begin
      drive(1'b0, 2);
      @(negedge clk);
      waited++;
    end while (o_shift != 4'd2 && waited < 10);
    checks++;
    if ({o_addr, o_busy, o_sum_clr, o_shift} !== {15'd0, 1'b1, 1'b1, 4'd2}) begin
      errors++; $display("FAIL restart_start: addr=%0d busy=%b clr=%b shift=%0d", o_addr, o_busy, o_sum_clr, o_shift);
    end
    while (o_busy && len < 20) begin
      len++;
      drive(1'b0, 2);
      @(negedge clk);
    end
    checks++;
    if (len != 4) begin
      errors++; $display("FAIL restart_len: len=%0d want 4", len);
    end
  endtask

  task automatic test_saturate();
    int waited = 0, len = 0;
    do begin
      drive(1'b1, 40);
      @(negedge clk);
      waited++;
    end while (!(o_busy && o_shift == 4'd15) && waited < 10);
    while (o_busy && len < 40000) begin
      len++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL sat_model: dut=%h model=%h", dut_vec, exp_vec());
      end
      drive(1'b1, 40);
      @(negedge clk);
    end
    checks++;
    if (len != 32768 || o_shift !== 4'd15) begin
      errors++; $display("FAIL sat_clear_len: len=%0d shift=%0d want 32768 15", len, o_shift);
    end
    waited = 0;
    do begin
      drive(1'b1, 14);
      @(negedge clk);
      waited++;
    end while (!(o_busy && o_shift == 4'd14) && waited < 10);
    waited = 0;
    while (o_busy && waited < 20000) begin
      drive(1'b1, 14);
      @(negedge clk);
      waited++;
    end
    waited = 0;
    while (o_drop_cnt != 16'hFFFF && waited < 40000) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL sat_model2: dut=%h model=%h", dut_vec, exp_vec());
      end
      drive(1'b1, 15);
      @(negedge clk);
      waited++;
    end
    repeat (20) begin
      drive(1'b1, 15);
      @(negedge clk);
    end
    checks++;
    if (o_drop_cnt !== 16'hFFFF || m_drop != 65535) begin
      errors++; $display("FAIL sat_drop: drop=%0d want 65535", o_drop_cnt);
    end
  endtask

  task automatic test_async_reset();
    int waited = 0;
    do begin
      drive(1'b0, 1);
      @(negedge clk);
      waited++;
    end while ((o_busy || o_shift != 4'd1) && waited < 50);
    repeat (3) drive(1'b1, 1);
    drive(1'b0, 1);
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1) begin
      errors++; $display("FAIL arst_run: valid=%b want 1", o_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_addr, o_shift, o_drop_cnt, o_busy} !== {1'b0, 15'd0, 4'd0, 16'd0, 1'b1}) begin
      errors++; $display("FAIL arst_run_abort: valid=%b addr=%0d shift=%0d drop=%0d busy=%b",
                         o_valid, o_addr, o_shift, o_drop_cnt, o_busy);
    end
    @(posedge clk); #1 rst_n = 1'b1; sel = 32'd5;
    waited = 0;
    do begin
      drive(1'b0, 5);
      @(negedge clk);
      waited++;
    end while (!(o_busy && o_shift == 4'd5 && o_addr >= 15'd3) && waited < 50);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_addr, o_shift, o_busy, o_sum_clr} !== {15'd0, 4'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL arst_clear_abort: addr=%0d shift=%0d busy=%b clr=%b", o_addr, o_shift, o_busy, o_sum_clr);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_random();
    int unsigned s = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 40) == 0)
        s = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 1000) : $urandom_range(0, 5);
      drive($urandom_range(0, 2) == 0, s);
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec() || (o_addr >> o_shift) != 0) begin
        errors++; $display("FAIL random: cyc=%0d dut=%h model=%h", c, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_clear_sweep();
    test_fill();
    test_change_run();
    test_restart();
    test_saturate();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
